// File: rtl/warp_dispatcher.sv
// warp_dispatcher
//   Front end of the SIMD cores. Host launches are tagged with a warp ID and
//   queued in a registered FIFO. The lowest-index idle core is loaded from the
//   FIFO head and released from reset. Matching completions are retired one per
//   cycle upstream, and the retired core is put back into reset.
//
//   Ports
//     clk, rst                 clock, async active-high reset
//     launch_valid/ready       launch handshake (ready = FIFO not full)
//     launch_start_pc          kernel start PC
//     launch_thread_count      requested threads (clamped to THREAD_COUNT)
//     launch_warp_id           ID the launch accepted on this edge receives
//     core_kernel[c]           {warp_id[3:0], start_pc[31:0], thread_count[TC_W-1:0]}
//     core_rst[c]              per-core active-high reset
//     core_is_finished[c]      completion from core c
//     core_finished_warp_id[c] ID reported by core c
//     warp_done_valid/id       one-cycle retire pulse and retired ID
//     busy                     FIFO non-empty or any core running
//     id_err                   sticky: a core finished with the wrong ID
//
//   Per-core FSM
//     state  | meaning
//     S_IDLE | core held in reset, kernel at reset value, dispatchable
//     S_RUN  | kernel loaded, core out of reset, waiting for completion
module warp_dispatcher #(
   parameter int NUM_CORES    = 4,
   parameter int QUEUE_DEPTH  = 8,
   parameter int TC_W         = 4,
   parameter int THREAD_COUNT = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             launch_valid,
   output logic                             launch_ready,
   input  logic [31:0]                      launch_start_pc,
   input  logic [TC_W-1:0]                  launch_thread_count,
   output logic [3:0]                       launch_warp_id,
   output logic [NUM_CORES-1:0][35+TC_W:0]  core_kernel,
   output logic [NUM_CORES-1:0]             core_rst,
   input  logic [NUM_CORES-1:0]             core_is_finished,
   input  logic [NUM_CORES-1:0][3:0]        core_finished_warp_id,
   output logic                             warp_done_valid,
   output logic [3:0]                       warp_done_id,
   output logic                             busy,
   output logic                             id_err
);

   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int KW = 36 + TC_W;
   localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [KW-1:0] KERNEL_RST = {4'hF, {(KW-4){1'b0}}};

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} core_state_t;

   core_state_t state_q [NUM_CORES];
   core_state_t state_d [NUM_CORES];

   logic [KW-1:0]   fifo_mem [QUEUE_DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic            fifo_empty;
   logic            fifo_full;
   logic [KW-1:0]   head;
   logic            head_zero;
   logic            push;
   logic            pop;
   logic [3:0]      id_ctr;
   logic [TC_W-1:0] tc_clamped;

   logic [NUM_CORES-1:0] eligible;
   logic [NUM_CORES-1:0] mismatch;
   logic                 grant_any;
   logic [CW-1:0]        grant_idx;
   logic                 idle_any;
   logic [CW-1:0]        idle_idx;
   logic                 dispatch;
   logic                 zero_retire;

   // Launch side / FIFO
   assign fifo_empty     = (wr_ptr == rd_ptr);
   assign fifo_full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign launch_ready   = !fifo_full;
   assign launch_warp_id = id_ctr;
   assign push           = launch_valid && launch_ready;
   assign head           = fifo_mem[rd_ptr[AW-1:0]];
   assign head_zero      = (head[TC_W-1:0] == '0);
   assign tc_clamped     = (launch_thread_count > TC_W'(THREAD_COUNT)) ?
                           TC_W'(THREAD_COUNT) : launch_thread_count;

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr[AW-1:0]] <= {id_ctr, launch_start_pc, tc_clamped};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         id_ctr <= 4'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            // 4'hF means "no warp", so the counter wraps after 14
            id_ctr <= (id_ctr == 4'd14) ? 4'd0 : id_ctr + 4'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Completion qualification, retire arbitration, dispatch selection
   always_comb begin
      eligible    = '0;
      mismatch    = '0;
      grant_any   = 1'b0;
      grant_idx   = '0;
      idle_any    = 1'b0;
      idle_idx    = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
         if (state_q[c] == S_RUN && core_is_finished[c]) begin
            if (core_finished_warp_id[c] == core_kernel[c][KW-1 -: 4])
               eligible[c] = 1'b1;
            else
               mismatch[c] = 1'b1;
         end
      end
      // Descending scan so the lowest index wins
      for (int c = NUM_CORES - 1; c >= 0; c--) begin
         if (eligible[c]) begin
            grant_any = 1'b1;
            grant_idx = CW'(c);
         end
         if (state_q[c] == S_IDLE) begin
            idle_any = 1'b1;
            idle_idx = CW'(c);
         end
      end
      // A zero-thread head never takes a core; it competes for the retire slot
      dispatch    = !fifo_empty && !head_zero && idle_any;
      zero_retire = !fifo_empty && head_zero && !grant_any;
      pop         = dispatch || zero_retire;
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CORES; c++)
            state_q[c] <= S_IDLE;
      end else begin
         for (int c = 0; c < NUM_CORES; c++)
            state_q[c] <= state_d[c];
      end
   end

   // FSM: next state. Only IDLE cores are dispatch candidates, so a core
   // retired on this edge spends at least one full cycle in reset.
   always_comb begin
      for (int c = 0; c < NUM_CORES; c++) begin
         state_d[c] = state_q[c];
         case (state_q[c])
            S_IDLE: if (dispatch && idle_idx == CW'(c))   state_d[c] = S_RUN;
            S_RUN:  if (grant_any && grant_idx == CW'(c)) state_d[c] = S_IDLE;
            default: state_d[c] = S_IDLE;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      busy = !fifo_empty;
      for (int c = 0; c < NUM_CORES; c++) begin
         core_rst[c] = (state_q[c] == S_IDLE);
         if (state_q[c] == S_RUN)
            busy = 1'b1;
      end
   end

   // Per-core kernel registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CORES; c++)
            core_kernel[c] <= KERNEL_RST;
      end else begin
         for (int c = 0; c < NUM_CORES; c++) begin
            if (grant_any && grant_idx == CW'(c))
               core_kernel[c] <= KERNEL_RST;
            else if (dispatch && idle_idx == CW'(c))
               core_kernel[c] <= head;
         end
      end
   end

   // Retire report and error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         warp_done_valid <= 1'b0;
         warp_done_id    <= 4'hF;
         id_err          <= 1'b0;
      end else begin
         warp_done_valid <= grant_any || zero_retire;
         if (grant_any)
            warp_done_id <= core_kernel[grant_idx][KW-1 -: 4];
         else if (zero_retire)
            warp_done_id <= head[KW-1 -: 4];
         if (|mismatch)
            id_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_warp_dispatcher.sv
module tb_warp_dispatcher;

   localparam int NC  = 4;
   localparam int TCW = 4;
   localparam int KW  = 36 + TCW;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  launch_valid;
   logic                  launch_ready;
   logic [31:0]           launch_start_pc;
   logic [TCW-1:0]        launch_thread_count;
   logic [3:0]            launch_warp_id;
   logic [NC-1:0][KW-1:0] core_kernel;
   logic [NC-1:0]         core_rst;
   logic [NC-1:0]         core_is_finished;
   logic [NC-1:0][3:0]    fin_id;
   logic                  warp_done_valid;
   logic [3:0]            warp_done_id;
   logic                  busy;
   logic                  id_err;

   logic [NC-1:0]         fin_req;
   int                    vectors = 0;
   int                    miscompares = 0;
   logic [3:0]            exp_q [$];
   logic [3:0]            id_model;

   // A core's finished flag is cleared while it is held in reset
   assign core_is_finished = fin_req & ~core_rst;

   always #5 clk = ~clk;

   warp_dispatcher #(.NUM_CORES(NC), .QUEUE_DEPTH(8), .TC_W(TCW), .THREAD_COUNT(8)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .launch_valid          (launch_valid),
      .launch_ready          (launch_ready),
      .launch_start_pc       (launch_start_pc),
      .launch_thread_count   (launch_thread_count),
      .launch_warp_id        (launch_warp_id),
      .core_kernel           (core_kernel),
      .core_rst              (core_rst),
      .core_is_finished      (core_is_finished),
      .core_finished_warp_id (fin_id),
      .warp_done_valid       (warp_done_valid),
      .warp_done_id          (warp_done_id),
      .busy                  (busy),
      .id_err                (id_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++)
         if (core_rst[c]) fin_req[c] = 1'b0;
   endtask

   task automatic next_id();
      id_model = (id_model == 4'd14) ? 4'd0 : id_model + 4'd1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      launch_valid = 1'b0;
      launch_start_pc = '0;
      launch_thread_count = '0;
      fin_req = '0;
      fin_id = '0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      id_model = 4'd0;
   endtask

   task automatic do_launch(input logic [31:0] pc, input logic [3:0] tc, output logic [3:0] id);
      launch_valid = 1'b1;
      launch_start_pc = pc;
      launch_thread_count = tc;
      vectors++;
      if (launch_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL launch_ready: got %b expected 1", launch_ready);
      end
      vectors++;
      if (launch_warp_id !== id_model) begin
         miscompares++;
         $display("FAIL launch_warp_id: got %0h expected %0h", launch_warp_id, id_model);
      end
      id = id_model;
      tick();
      launch_valid = 1'b0;
      next_id();
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s drain: got %0d retires outstanding expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Scoreboard consumer: every retire pulse must match the oldest expectation
   task automatic monitor();
      logic [3:0] e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && warp_done_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL done_unexpected: got id %0h expected no retire", warp_done_id);
            end else begin
               e = exp_q.pop_front();
               if (warp_done_id !== e) begin
                  miscompares++;
                  $display("FAIL done_id: got %0h expected %0h", warp_done_id, e);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (core_rst !== '1 || busy !== 1'b0 || id_err !== 1'b0 || launch_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ctrl: got rst=%b busy=%b err=%b rdy=%b expected 1111 0 0 1",
                  core_rst, busy, id_err, launch_ready);
      end
      vectors++;
      if (warp_done_valid !== 1'b0 || warp_done_id !== 4'hF || launch_warp_id !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_done: got v=%b id=%h lid=%h expected 0 f 0",
                  warp_done_valid, warp_done_id, launch_warp_id);
      end
      for (int c = 0; c < NC; c++) begin
         vectors++;
         if (core_kernel[c] !== {4'hF, 36'h0}) begin
            miscompares++;
            $display("FAIL reset_kernel%0d: got %h expected %h", c, core_kernel[c], {4'hF, 36'h0});
         end
      end
   endtask

   task automatic test_single();
      logic [3:0] id;
      do_reset();
      do_launch(32'h100, 4'd8, id);
      vectors++;
      if (core_rst[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL single_no_bypass: got core_rst0=%b expected 1", core_rst[0]);
      end
      tick();
      vectors++;
      if (core_rst[0] !== 1'b0 || core_kernel[0] !== {4'd0, 32'h100, 4'd8}) begin
         miscompares++;
         $display("FAIL single_dispatch: got rst0=%b k=%h expected 0 %h",
                  core_rst[0], core_kernel[0], {4'd0, 32'h100, 4'd8});
      end
      fin_id[0] = id;
      fin_req[0] = 1'b1;
      exp_q.push_back(id);
      tick();
      vectors++;
      if (core_rst[0] !== 1'b1 || warp_done_valid !== 1'b1 || core_kernel[0] !== {4'hF, 36'h0}) begin
         miscompares++;
         $display("FAIL single_retire: got rst0=%b v=%b k=%h expected 1 1 %h",
                  core_rst[0], warp_done_valid, core_kernel[0], {4'hF, 36'h0});
      end
      wait_drain("single");
   endtask

   task automatic test_fill();
      int  q_cnt = 0;
      int  free  = NC;
      bit  exp_rdy;
      bit  do_pop;
      do_reset();
      launch_valid = 1'b1;
      launch_thread_count = 4'd5;
      for (int i = 0; i < 13; i++) begin
         launch_start_pc = 32'h1000 + i;
         exp_rdy = (q_cnt < 8);
         vectors++;
         if (launch_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL fill_ready[%0d]: got %b expected %b", i, launch_ready, exp_rdy);
         end
         if (exp_rdy) begin
            vectors++;
            if (launch_warp_id !== id_model) begin
               miscompares++;
               $display("FAIL fill_id[%0d]: got %0h expected %0h", i, launch_warp_id, id_model);
            end
         end
         do_pop = (q_cnt > 0) && (free > 0);
         tick();
         if (do_pop) begin q_cnt--; free--; end
         if (exp_rdy) begin q_cnt++; next_id(); end
      end
      launch_valid = 1'b0;
      vectors++;
      if (launch_ready !== 1'b0 || core_rst !== '0 || busy !== 1'b1 || launch_warp_id !== id_model) begin
         miscompares++;
         $display("FAIL fill_end: got rdy=%b rst=%b busy=%b lid=%0h expected 0 0000 1 %0h",
                  launch_ready, core_rst, busy, launch_warp_id, id_model);
      end
      for (int c = 0; c < NC; c++) begin
         vectors++;
         if (core_kernel[c] !== {4'(c), 32'h1000 + 32'(c), 4'd5}) begin
            miscompares++;
            $display("FAIL fill_kernel%0d: got %h expected %h", c, core_kernel[c],
                     {4'(c), 32'h1000 + 32'(c), 4'd5});
         end
      end
   endtask

   task automatic test_simul_finish();
      logic [3:0] id;
      do_reset();
      for (int i = 0; i < 5; i++)
         do_launch(32'h2000 + 32'(i), 4'd4, id);
      vectors++;
      if (core_rst !== '0) begin
         miscompares++;
         $display("FAIL simul_busy: got core_rst=%b expected 0000", core_rst);
      end
      fin_id[0] = 4'd0; fin_id[2] = 4'd2; fin_id[3] = 4'd3;
      fin_req = 4'b1101;
      exp_q.push_back(4'd0); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
      tick();
      vectors++;
      if (warp_done_valid !== 1'b1 || core_rst !== 4'b0001) begin
         miscompares++;
         $display("FAIL simul_f0: got v=%b rst=%b expected 1 0001", warp_done_valid, core_rst);
      end
      tick();
      vectors++;
      if (warp_done_valid !== 1'b1 || core_rst !== 4'b0100 || core_kernel[0][KW-1 -: 4] !== 4'd4) begin
         miscompares++;
         $display("FAIL simul_f1: got v=%b rst=%b k0id=%0h expected 1 0100 4",
                  warp_done_valid, core_rst, core_kernel[0][KW-1 -: 4]);
      end
      tick();
      vectors++;
      if (warp_done_valid !== 1'b1 || core_rst !== 4'b1100) begin
         miscompares++;
         $display("FAIL simul_f2: got v=%b rst=%b expected 1 1100", warp_done_valid, core_rst);
      end
      wait_drain("simul");
   endtask

   task automatic test_id_wrap();
      logic [3:0] id;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         do_launch(32'h3000 + 32'(i), 4'd2, id);
         tick();
         vectors++;
         if (core_kernel[0][KW-1 -: 4] !== id_model - 4'd1 && !(id_model == 4'd0 && core_kernel[0][KW-1 -: 4] === 4'd14)) begin
            miscompares++;
            $display("FAIL wrap_kernel_id[%0d]: got %0h expected %0h", i, core_kernel[0][KW-1 -: 4], id);
         end
         fin_id[0] = id;
         fin_req[0] = 1'b1;
         exp_q.push_back(id);
         tick();
         wait_drain("wrap");
      end
      vectors++;
      if (launch_warp_id !== 4'd1) begin
         miscompares++;
         $display("FAIL wrap_next_id: got %0h expected 1", launch_warp_id);
      end
   endtask

   task automatic test_zero_and_mismatch();
      logic [3:0] id;
      logic [3:0] id_a;
      logic [3:0] id_b;
      do_reset();
      do_launch(32'h200, 4'd0, id);
      exp_q.push_back(id);
      tick();
      vectors++;
      if (warp_done_valid !== 1'b1 || core_rst !== '1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_retire: got v=%b rst=%b busy=%b expected 1 1111 0",
                  warp_done_valid, core_rst, busy);
      end
      wait_drain("zero");
      do_launch(32'h300, 4'd13, id_a);
      do_launch(32'h400, 4'd3, id_b);
      tick();
      vectors++;
      if (core_kernel[0] !== {4'd1, 32'h300, 4'd8} || core_kernel[1] !== {4'd2, 32'h400, 4'd3}) begin
         miscompares++;
         $display("FAIL clamp_kernel: got %h %h expected %h %h", core_kernel[0], core_kernel[1],
                  {4'd1, 32'h300, 4'd8}, {4'd2, 32'h400, 4'd3});
      end
      fin_id[1] = 4'd9;
      fin_req[1] = 1'b1;
      tick();
      tick();
      vectors++;
      if (id_err !== 1'b1 || core_rst[1] !== 1'b0 || warp_done_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mismatch: got err=%b rst1=%b v=%b expected 1 0 0",
                  id_err, core_rst[1], warp_done_valid);
      end
      fin_req[1] = 1'b0;
      tick();
      vectors++;
      if (id_err !== 1'b1) begin
         miscompares++;
         $display("FAIL mismatch_sticky: got %b expected 1", id_err);
      end
   endtask

   task automatic test_midrun_reset();
      logic [3:0] id;
      do_reset();
      for (int i = 0; i < 7; i++)
         do_launch(32'h5000 + 32'(i), 4'd6, id);
      fin_id[0] = 4'd0;
      fin_req[0] = 1'b1;
      rst = 1'b1;
      #1;
      vectors++;
      if (core_rst !== '1 || busy !== 1'b0 || warp_done_valid !== 1'b0 || launch_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_async: got rst=%b busy=%b v=%b rdy=%b expected 1111 0 0 1",
                  core_rst, busy, warp_done_valid, launch_ready);
      end
      exp_q.delete();
      fin_req = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      id_model = 4'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (warp_done_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_quiet[%0d]: got v=%b busy=%b expected 0 0", i, warp_done_valid, busy);
         end
      end
      do_launch(32'h600, 4'd7, id);
      tick();
      vectors++;
      if (core_kernel[0] !== {4'd0, 32'h600, 4'd7} || core_rst !== 4'b1110) begin
         miscompares++;
         $display("FAIL midrst_relaunch: got k=%h rst=%b expected %h 1110",
                  core_kernel[0], core_rst, {4'd0, 32'h600, 4'd7});
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_single();
      test_fill();
      test_simul_finish();
      test_id_wrap();
      test_zero_and_mismatch();
      test_midrun_reset();
      test_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
